// File: rtl/conv_operand_memory.sv
// conv_operand_memory
//   Operand store for one convolution layer. Holds input activations and
//   kernel weights as DATA_SIZE-bit words. Stored data is never interpreted
//   or modified.
//
//   Optional build macro: RD_BYPASS_EN
//     defined   - a read of the word being written in the same cycle returns
//                 wr_data (write-first forwarding, per bank)
//     undefined - such a read returns the old contents (read-first)
//   Read latency is one clock in both builds.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   act_wr_en, wt_wr_en      write strobes for activation / weight bank
//   wr_data                  shared write word
//   wr_idx3..wr_idx0         write index (in-map, entry/out-map, y, x)
//   act_rd_entry/y/x         activation read address
//   act_rd_data              activation read word (registered)
//   wt_rd_in/out/y/x         weight read address
//   wt_rd_data               weight read word (registered)
//   wr_err                   one-cycle pulse after an out-of-range write
module conv_operand_memory #(
  parameter int unsigned NUM_INPUTS  = 1,
  parameter int unsigned NUM_OUTPUTS = 1,
  parameter int unsigned INPUT_DIM   = 5,
  parameter int unsigned KERNEL_DIM  = 3,
  parameter int unsigned DATA_SIZE   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 act_wr_en,
  input  logic                 wt_wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [15:0]          wr_idx3,
  input  logic [15:0]          wr_idx2,
  input  logic [15:0]          wr_idx1,
  input  logic [15:0]          wr_idx0,
  input  logic [15:0]          act_rd_entry,
  input  logic [15:0]          act_rd_y,
  input  logic [15:0]          act_rd_x,
  output logic [DATA_SIZE-1:0] act_rd_data,
  input  logic [15:0]          wt_rd_in,
  input  logic [15:0]          wt_rd_out,
  input  logic [15:0]          wt_rd_y,
  input  logic [15:0]          wt_rd_x,
  output logic [DATA_SIZE-1:0] wt_rd_data,
  output logic                 wr_err
);

  localparam int unsigned ACT_WORDS = NUM_INPUTS * INPUT_DIM * INPUT_DIM;
  localparam int unsigned WT_WORDS  = NUM_INPUTS * NUM_OUTPUTS * KERNEL_DIM * KERNEL_DIM;
  localparam int unsigned ACT_AW    = (ACT_WORDS > 1) ? $clog2(ACT_WORDS) : 1;
  localparam int unsigned WT_AW     = (WT_WORDS > 1) ? $clog2(WT_WORDS) : 1;

  // Each index is checked against its own dimension, so a wide x can never
  // spill into the next row after linearising.
  function automatic logic act_in_range(input logic [15:0] e, input logic [15:0] y,
                                        input logic [15:0] x);
    return (32'(e) < NUM_INPUTS) && (32'(y) < INPUT_DIM) && (32'(x) < INPUT_DIM);
  endfunction

  function automatic logic wt_in_range(input logic [15:0] i, input logic [15:0] o,
                                       input logic [15:0] y, input logic [15:0] x);
    return (32'(i) < NUM_INPUTS) && (32'(o) < NUM_OUTPUTS) &&
           (32'(y) < KERNEL_DIM) && (32'(x) < KERNEL_DIM);
  endfunction

  function automatic logic [ACT_AW-1:0] act_addr(input logic [15:0] e, input logic [15:0] y,
                                                 input logic [15:0] x);
    return ACT_AW'((32'(e) * INPUT_DIM + 32'(y)) * INPUT_DIM + 32'(x));
  endfunction

  function automatic logic [WT_AW-1:0] wt_addr(input logic [15:0] i, input logic [15:0] o,
                                               input logic [15:0] y, input logic [15:0] x);
    return WT_AW'(((32'(i) * NUM_OUTPUTS + 32'(o)) * KERNEL_DIM + 32'(y)) * KERNEL_DIM
                  + 32'(x));
  endfunction

  logic [DATA_SIZE-1:0] act_mem [ACT_WORDS];
  logic [DATA_SIZE-1:0] wt_mem  [WT_WORDS];

  logic              act_wr_ok, wt_wr_ok, act_rd_ok, wt_rd_ok;
  logic [ACT_AW-1:0] act_wa, act_ra;
  logic [WT_AW-1:0]  wt_wa, wt_ra;
  logic              act_hit, wt_hit;

  assign act_wr_ok = act_in_range(wr_idx2, wr_idx1, wr_idx0);
  assign wt_wr_ok  = wt_in_range(wr_idx3, wr_idx2, wr_idx1, wr_idx0);
  assign act_rd_ok = act_in_range(act_rd_entry, act_rd_y, act_rd_x);
  assign wt_rd_ok  = wt_in_range(wt_rd_in, wt_rd_out, wt_rd_y, wt_rd_x);
  assign act_wa    = act_addr(wr_idx2, wr_idx1, wr_idx0);
  assign wt_wa     = wt_addr(wr_idx3, wr_idx2, wr_idx1, wr_idx0);
  assign act_ra    = act_addr(act_rd_entry, act_rd_y, act_rd_x);
  assign wt_ra     = wt_addr(wt_rd_in, wt_rd_out, wt_rd_y, wt_rd_x);

`ifdef RD_BYPASS_EN
  assign act_hit = act_wr_en && act_wr_ok && (act_wa == act_ra);
  assign wt_hit  = wt_wr_en && wt_wr_ok && (wt_wa == wt_ra);
`else
  assign act_hit = 1'b0;
  assign wt_hit  = 1'b0;
`endif

  logic [DATA_SIZE-1:0] act_rd_p1, wt_rd_p1;
  logic                 wr_err_p1;

  // ---- stage p1: storage update and registered read ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ACT_WORDS); i++) act_mem[i] <= '0;
      for (int i = 0; i < int'(WT_WORDS); i++)  wt_mem[i]  <= '0;
      act_rd_p1 <= '0;
      wt_rd_p1  <= '0;
      wr_err_p1 <= 1'b0;
    end else begin
      if (act_wr_en && act_wr_ok) act_mem[act_wa] <= wr_data;
      if (wt_wr_en && wt_wr_ok)   wt_mem[wt_wa]   <= wr_data;
      wr_err_p1 <= (act_wr_en && !act_wr_ok) || (wt_wr_en && !wt_wr_ok);

      if (!act_rd_ok)   act_rd_p1 <= '0;
      else if (act_hit) act_rd_p1 <= wr_data;
      else              act_rd_p1 <= act_mem[act_ra];

      if (!wt_rd_ok)    wt_rd_p1 <= '0;
      else if (wt_hit)  wt_rd_p1 <= wr_data;
      else              wt_rd_p1 <= wt_mem[wt_ra];
    end
  end

  assign act_rd_data = act_rd_p1;
  assign wt_rd_data  = wt_rd_p1;
  assign wr_err      = wr_err_p1;

endmodule

// File: tb/tb_conv_operand_memory.sv
module tb_conv_operand_memory;

  localparam int NI = 1;
  localparam int NO = 1;
  localparam int ID = 5;
  localparam int KD = 3;
  localparam int DS = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          act_wr_en = 1'b0, wt_wr_en = 1'b0;
  logic [DS-1:0] wr_data = '0;
  logic [15:0]   wr_idx3 = '0, wr_idx2 = '0, wr_idx1 = '0, wr_idx0 = '0;
  logic [15:0]   act_rd_entry = '0, act_rd_y = '0, act_rd_x = '0;
  logic [15:0]   wt_rd_in = '0, wt_rd_out = '0, wt_rd_y = '0, wt_rd_x = '0;
  logic [DS-1:0] act_rd_data, wt_rd_data;
  logic          wr_err;

  int total = 0;
  int bad   = 0;

  // Reference model: sparse maps keyed by the logical coordinates.
  logic [DS-1:0] act_m [logic [47:0]];
  logic [DS-1:0] wt_m  [logic [63:0]];

  conv_operand_memory #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .INPUT_DIM(ID), .KERNEL_DIM(KD), .DATA_SIZE(DS)
  ) dut (
    .clk(clk), .rst(rst),
    .act_wr_en(act_wr_en), .wt_wr_en(wt_wr_en), .wr_data(wr_data),
    .wr_idx3(wr_idx3), .wr_idx2(wr_idx2), .wr_idx1(wr_idx1), .wr_idx0(wr_idx0),
    .act_rd_entry(act_rd_entry), .act_rd_y(act_rd_y), .act_rd_x(act_rd_x),
    .act_rd_data(act_rd_data),
    .wt_rd_in(wt_rd_in), .wt_rd_out(wt_rd_out), .wt_rd_y(wt_rd_y), .wt_rd_x(wt_rd_x),
    .wt_rd_data(wt_rd_data),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic a_ok(input logic [15:0] e, y, x);
    return (int'(e) < NI) && (int'(y) < ID) && (int'(x) < ID);
  endfunction

  function automatic logic w_ok(input logic [15:0] i, o, y, x);
    return (int'(i) < NI) && (int'(o) < NO) && (int'(y) < KD) && (int'(x) < KD);
  endfunction

  task automatic chk(input string tag, input logic [DS-1:0] got, input logic [DS-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive a write and both reads, then check the registered results.
  task automatic step(input string tag, input logic awe, input logic wwe,
                      input logic [DS-1:0] d,
                      input logic [15:0] i3, input logic [15:0] i2,
                      input logic [15:0] i1, input logic [15:0] i0,
                      input logic [15:0] ae, input logic [15:0] ay, input logic [15:0] ax,
                      input logic [15:0] wi, input logic [15:0] wo,
                      input logic [15:0] wy, input logic [15:0] wx);
    logic [DS-1:0] ea, ew;
    logic          ee, aw_ok, ww_ok;
    logic [47:0]   ka, kaw;
    logic [63:0]   kw, kww;
    @(negedge clk);
    act_wr_en = awe; wt_wr_en = wwe; wr_data = d;
    wr_idx3 = i3; wr_idx2 = i2; wr_idx1 = i1; wr_idx0 = i0;
    act_rd_entry = ae; act_rd_y = ay; act_rd_x = ax;
    wt_rd_in = wi; wt_rd_out = wo; wt_rd_y = wy; wt_rd_x = wx;
    aw_ok = a_ok(i2, i1, i0);
    ww_ok = w_ok(i3, i2, i1, i0);
    ka  = {ae, ay, ax};
    kaw = {i2, i1, i0};
    kw  = {wi, wo, wy, wx};
    kww = {i3, i2, i1, i0};
    ea = '0;
    if (a_ok(ae, ay, ax)) begin
      if (act_m.exists(ka)) ea = act_m[ka];
`ifdef RD_BYPASS_EN
      if (awe && aw_ok && ka == kaw) ea = d;
`endif
    end
    ew = '0;
    if (w_ok(wi, wo, wy, wx)) begin
      if (wt_m.exists(kw)) ew = wt_m[kw];
`ifdef RD_BYPASS_EN
      if (wwe && ww_ok && kw == kww) ew = d;
`endif
    end
    ee = (awe && !aw_ok) || (wwe && !ww_ok);
    @(posedge clk);
    #1;
    chk({tag, ".act"}, act_rd_data, ea);
    chk({tag, ".wt"}, wt_rd_data, ew);
    chk({tag, ".err"}, {63'b0, wr_err}, {63'b0, ee});
    if (awe && aw_ok) act_m[kaw] = d;
    if (wwe && ww_ok) wt_m[kww] = d;
  endtask

  function automatic logic [15:0] ridx(input int dim);
    if ($urandom_range(0, 9) == 0) return 16'(dim + int'($urandom_range(0, 3)));
    return 16'($urandom_range(0, dim - 1));
  endfunction

  initial begin
    logic          awe, wwe;
    logic [DS-1:0] d;
    logic [15:0]   i3, i2, i1, i0, ae, ay, ax, wi, wo, wy, wx;

    // Reset state
    #2;
    chk("rst.act", act_rd_data, '0);
    chk("rst.wt", wt_rd_data, '0);
    chk("rst.err", {63'b0, wr_err}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Empty memory reads as zero
    step("empty", 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);

    // Activation write then read back, neighbour stays zero
    step("a_wr", 1, 0, 64'h3FF8000000000000, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    step("a_rd", 0, 0, '0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    step("a_nb", 0, 0, '0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);

    // Separate bank writes, simultaneous reads
    step("w_wr", 0, 1, 64'h4000000000000000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("a_wr2", 1, 0, 64'hBFF0000000000000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("both_rd", 0, 0, '0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1);

    // Out-of-range write: error pulse, no aliasing, out-of-range read is zero
    step("oor_wr", 1, 0, 64'hDEADBEEFCAFEF00D, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    step("oor_alias", 0, 0, '0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("oor_rd", 0, 0, '0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 3, 0);

    // Both enables: weight out of range, activation still written
    step("mix_err", 1, 1, 64'h0123456789ABCDEF, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0);
    step("mix_rd", 0, 0, '0, 0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 0);
    // Both enables, both in range
    step("dual_wr", 1, 1, 64'h5555AAAA5555AAAA, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    step("dual_rd", 0, 0, '0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 2, 2);

    // Same-cycle read/write collision
    step("col_pre", 1, 0, 64'h7, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    step("col_hit", 1, 0, 64'h1, 0, 0, 3, 3, 0, 3, 3, 0, 0, 0, 0);
    step("col_post", 0, 0, '0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    step("colw_hit", 0, 1, 64'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Park the reads on non-zero words, then reset between edges
    step("pre_rst", 0, 0, '0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.act", act_rd_data, '0);
    chk("arst.wt", wt_rd_data, '0);
    chk("arst.err", {63'b0, wr_err}, '0);
    act_m.delete();
    wt_m.delete();
    @(negedge clk);
    rst = 1'b0;
    step("post_rst1", 0, 0, '0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 1);
    step("post_rst2", 0, 0, '0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 2, 2);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      awe = 1'($urandom_range(0, 1));
      wwe = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      i3 = ridx(NI);
      if (wwe && !awe) i2 = ridx(NO); else i2 = ridx(NI);
      if (wwe && !awe) begin i1 = ridx(KD); i0 = ridx(KD); end
      else begin i1 = ridx(ID); i0 = ridx(ID); end
      ae = ridx(NI); ay = ridx(ID); ax = ridx(ID);
      wi = ridx(NI); wo = ridx(NO); wy = ridx(KD); wx = ridx(KD);
      if ($urandom_range(0, 3) == 0) begin ae = i2; ay = i1; ax = i0; end
      if ($urandom_range(0, 3) == 0) begin wi = i3; wo = i2; wy = i1; wx = i0; end
      step("rand", awe, wwe, d, i3, i2, i1, i0, ae, ay, ax, wi, wo, wy, wx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
